// File: rtl/ariscv_async2sync_rx_pkg.sv
// Shared types for the async<->sync boundary blocks.
// Receiver FSM states and default synchronizer depth.
package ariscv_async_pkg;

  typedef enum logic [1:0] {
    RESYNC  = 2'd0,
    IDLE    = 2'd1,
    WAIT_LO = 2'd2
  } rx_state_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/ariscv_async2sync_rx_if.sv
// Receiver bus: 4-phase req/ack side plus valid/ready side.
// master = sender/consumer environment, slave = receiver.
interface ariscv_async2sync_rx_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);

  logic                          i_req;
  logic [DATA_W-1:0]             i_data;
  logic                          o_ack;
  logic                          o_valid;
  logic                          i_ready;
  logic [DATA_W-1:0]             o_data;
  logic [$clog2(FIFO_DEPTH):0]   o_count;

  modport master (
    output i_req,
    output i_data,
    output i_ready,
    input  o_ack,
    input  o_valid,
    input  o_data,
    input  o_count
  );

  modport slave (
    input  i_req,
    input  i_data,
    input  i_ready,
    output o_ack,
    output o_valid,
    output o_data,
    output o_count
  );

endinterface

// File: rtl/ariscv_async2sync_rx_sync_ff.sv
// Multi-flop synchronizer, async active-high reset to 0.
// Output is the last stage only.
module ariscv_sync_ff #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_ff [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        r_ff[i] <= '0;
    end else begin
      r_ff[0] <= i_d;
      for (int i = 1; i < STAGES; i++)
        r_ff[i] <= r_ff[i-1];
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/ariscv_async2sync_rx.sv
// 4-phase bundled-data receiver: sync req, capture word, ack,
// and present words on a show-ahead valid/ready FIFO.
import ariscv_async_pkg::*;

module ariscv_async2sync_rx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_async,
  ariscv_async2sync_rx_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic              w_req_s;
  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_flushed;
  logic [FW-1:0]     r_flush;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_count;

  ariscv_sync_ff #(
    .STAGES (SYNC_STAGES),
    .W      (1)
  ) u_req_sync (
    .clk (clk),
    .rst (rst_async),
    .i_d (bus.i_req),
    .o_q (w_req_s)
  );

  // The synchronizer also resets to 0, so req_s=0 right after reset
  // says nothing; wait until it has refilled from the real i_req.
  assign w_flushed = (r_flush == FW'(SYNC_STAGES));

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async)
      r_flush <= '0;
    else if (r_state == RESYNC && !w_flushed)
      r_flush <= r_flush + FW'(1);
  end

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && bus.i_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    unique case (r_state)
      RESYNC: begin
        w_ack_nxt = 1'b0;
        if (w_flushed && !w_req_s)
          w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = RESYNC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state <= RESYNC;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= bus.i_data;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  assign bus.o_ack   = r_ack;
  assign bus.o_valid = (r_count != '0);
  assign bus.o_data  = r_mem[r_rd];
  assign bus.o_count = r_count;

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst_async) !(w_push && w_full)
  );

endmodule

// File: tb/tb_ariscv_async2sync_rx.sv
// Bench for ariscv_async2sync_rx: directed handshakes,
// scoreboard queue checked by a negedge monitor.
module tb_ariscv_async2sync_rx;

  localparam int DW = 32;
  localparam int FD = 4;

  logic clk;
  logic rst_async;
  int   n_cmp;
  int   n_bad;
  logic [DW-1:0] q[$];
  bit   s_done;
  bit   r_done;

  ariscv_async2sync_rx_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) bus ();

  ariscv_async2sync_rx #(
    .DATA_W      (DW),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(logic lvl, string nm);
    int t;
    t = 0;
    while (bus.o_ack !== lvl && t < 3000) begin
      #1;
      t++;
    end
    chk({"ack_wait_", nm}, 64'(bus.o_ack), 64'(lvl));
  endtask

  task automatic send(logic [DW-1:0] d, int dly);
    wait_ack(1'b0, "pre");
    #(dly);
    bus.i_data = d;
    q.push_back(d);
    #(dly);
    bus.i_req = 1'b1;
    wait_ack(1'b1, "hi");
    #(dly);
    bus.i_req = 1'b0;
    wait_ack(1'b0, "lo");
  endtask

  task automatic drain(string nm);
    int t;
    bus.i_ready = 1'b1;
    t = 0;
    while (bus.o_count != 0 && t < 300) begin
      tick(1);
      t++;
    end
    bus.i_ready = 1'b0;
    chk({"drain_", nm}, 64'(bus.o_count), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_async && bus.o_valid && bus.i_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got %0h expected none", bus.o_data);
      end else begin
        chk("sb_data", 64'(bus.o_data), 64'(q.pop_front()));
      end
    end
  end

  // ack may only rise while req is high and fall while req is low
  always @(bus.o_ack) begin
    if (!rst_async)
      chk("ack_proto", 64'(bus.i_req), 64'(bus.o_ack));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    s_done = 0;
    r_done = 0;
    rst_async = 1'b1;
    bus.i_req = 1'b0;
    bus.i_data = '0;
    bus.i_ready = 1'b0;
    #12;
    chk("rst_ack", 64'(bus.o_ack), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_data", 64'(bus.o_data), 64'd0);
    tick(1);
    rst_async = 1'b0;
    tick(6);

    // single word, exact latency
    bus.i_data = 32'hDEADBEEF;
    q.push_back(32'hDEADBEEF);
    bus.i_req = 1'b1;
    tick(2);
    chk("lat_ack_e2", 64'(bus.o_ack), 64'd0);
    chk("lat_valid_e2", 64'(bus.o_valid), 64'd0);
    tick(1);
    chk("lat_ack_e3", 64'(bus.o_ack), 64'd1);
    chk("lat_valid_e3", 64'(bus.o_valid), 64'd1);
    chk("lat_data_e3", 64'(bus.o_data), 64'hDEADBEEF);
    chk("lat_count_e3", 64'(bus.o_count), 64'd1);
    bus.i_req = 1'b0;
    tick(2);
    chk("fall_ack_e2", 64'(bus.o_ack), 64'd1);
    tick(1);
    chk("fall_ack_e3", 64'(bus.o_ack), 64'd0);
    bus.i_ready = 1'b1;
    tick(1);
    bus.i_ready = 1'b0;
    chk("single_count", 64'(bus.o_count), 64'd0);
    chk("single_sb", 64'(q.size()), 64'd0);

    // burst of 6 against a stalled consumer
    s_done = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(DW'(i), 3);
        s_done = 1;
      end
    join_none
    tick(80);
    chk("burst_count", 64'(bus.o_count), 64'd4);
    chk("burst_ack_stall", 64'(bus.o_ack), 64'd0);
    chk("burst_req_held", 64'(bus.i_req), 64'd1);
    chk("burst_head", 64'(bus.o_data), 64'd1);
    bus.i_ready = 1'b1;
    tick(1);
    bus.i_ready = 1'b0;
    tick(1);
    chk("burst_ack_5th", 64'(bus.o_ack), 64'd1);
    chk("burst_count_5th", 64'(bus.o_count), 64'd4);
    bus.i_ready = 1'b1;
    for (int t = 0; t < 300 && !s_done; t++)
      tick(1);
    chk("burst_done", 64'(s_done), 64'd1);
    drain("burst");

    // push and pop on the same edge at count 2
    tick(1);
    send(32'hA1, 2);
    send(32'hA2, 2);
    tick(1);
    chk("pp_pre_count", 64'(bus.o_count), 64'd2);
    bus.i_data = 32'hA3;
    q.push_back(32'hA3);
    bus.i_req = 1'b1;
    tick(2);
    bus.i_ready = 1'b1;
    tick(1);
    bus.i_ready = 1'b0;
    chk("pp_count", 64'(bus.o_count), 64'd2);
    chk("pp_ack", 64'(bus.o_ack), 64'd1);
    chk("pp_head", 64'(bus.o_data), 64'hA2);
    bus.i_req = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(32'hB0 + DW'(i), 1);
    drain("wrap");

    // reset in WAIT_LO with req held high
    tick(1);
    bus.i_data = 32'h77;
    bus.i_req = 1'b1;
    wait_ack(1'b1, "rst_pre");
    tick(1);
    rst_async = 1'b1;
    #1;
    chk("midrst_ack", 64'(bus.o_ack), 64'd0);
    chk("midrst_count", 64'(bus.o_count), 64'd0);
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    tick(1);
    rst_async = 1'b0;
    tick(10);
    chk("resync_count", 64'(bus.o_count), 64'd0);
    chk("resync_ack", 64'(bus.o_ack), 64'd0);
    bus.i_req = 1'b0;
    tick(5);
    send(32'h5, 2);
    tick(1);
    chk("resync_one", 64'(bus.o_count), 64'd1);
    chk("resync_data", 64'(bus.o_data), 64'h5);
    drain("resync");

    // random async timing with random back-pressure
    s_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send($urandom, $urandom_range(0, 20));
        s_done = 1;
      end
      begin
        for (int t = 0; t < 5000 && !s_done; t++) begin
          @(posedge clk);
          #1;
          bus.i_ready = 1'($urandom_range(0, 1));
        end
        r_done = 1;
      end
    join
    chk("rand_done", 64'(s_done), 64'd1);
    drain("rand");
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
